// File: rtl/shift_left_sequential.sv
// shift_left_sequential
// Multi-cycle 32-bit logical shift left (Res = a << b, zero fill).
// One binary-weighted mux stage (1, 2, 4, 8, 16) is applied per clock.
// Shift amounts of 32 or more complete in one cycle with a zero result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; busy = 0, done = 0
// SHIFT | applying stage 0..4 of the shift, one per clock; busy = 1
// DONE  | Res valid, done = 1 for one cycle; start accepted here too
module shift_left_sequential (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] Res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic [31:0] acc_shf;
    logic [4:0]  amt;
    logic [2:0]  stage;
    logic        accept;
    logic        over;
    logic        last_stage;

    // Request acceptance and out-of-range detection on the raw inputs
    always_comb begin
        accept     = start && ((state == IDLE) || (state == DONE));
        over       = |b[31:5];
        last_stage = (stage == 3'd4);
    end

    // Shift stage selected by the stage counter; weight doubles each stage
    always_comb begin
        acc_shf = acc;
        case (stage)
            3'd0:    if (amt[0]) acc_shf = acc << 1;
            3'd1:    if (amt[1]) acc_shf = acc << 2;
            3'd2:    if (amt[2]) acc_shf = acc << 4;
            3'd3:    if (amt[3]) acc_shf = acc << 8;
            3'd4:    if (amt[4]) acc_shf = acc << 16;
            default: acc_shf = acc;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DONE can re-accept so back-to-back requests skip IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = over ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_stage) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = over ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-stage accumulation and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= 32'd0;
            amt   <= 5'd0;
            stage <= 3'd0;
            Res   <= 32'd0;
        end else if (accept) begin
            acc   <= a;
            amt   <= b[4:0];
            stage <= 3'd0;
            if (over) begin
                Res <= 32'd0;
            end
        end else if (state == SHIFT) begin
            acc   <= acc_shf;
            stage <= stage + 3'd1;
            if (last_stage) begin
                Res <= acc_shf;
            end
        end
    end

    // Status flags decoded straight from the state register
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_left_sequential.sv
// Bench for shift_left_sequential: directed cases plus random operands,
// checked against an arithmetic reference (a << b, zero for b >= 32).
module tb_shift_left_sequential;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] Res;

    int total;
    int bad;

    shift_left_sequential dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .Res     (Res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb);
        if (mb >= 32) return 32'd0;
        return ma << mb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request from IDLE, with full latency/handshake checks
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input string tag);
        logic [31:0] exp;
        exp = model(ta, tb_v);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (tb_v >= 32) begin
            chk({tag, ".oor_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, ".oor_done"}, {31'd0, done}, 32'd1);
            chk({tag, ".oor_res"}, Res, 32'd0);
        end else begin
            chk({tag, ".busy0"}, {31'd0, busy}, 32'd1);
            chk({tag, ".nodone0"}, {31'd0, done}, 32'd0);
            for (int i = 1; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
                chk({tag, ".nodone"}, {31'd0, done}, 32'd0);
            end
            @(posedge clk);
            #1;
            chk({tag, ".done"}, {31'd0, done}, 32'd1);
            chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
            chk({tag, ".res"}, Res, exp);
        end
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".res_hold"}, Res, exp);
    endtask

    initial begin
        int          ndone;
        logic [31:0] res_at_done;
        logic [31:0] rb;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = 32'd0;
        b       = 32'd0;

        #1;
        chk("rst.res", Res, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(32'h0000_0001, 32'd31, "b31");
        do_op(32'hDEAD_BEEF, 32'd4, "b4");
        do_op(32'hDEAD_BEEF, 32'd0, "b0");
        do_op(32'hDEAD_BEEF, 32'd13, "b13");
        do_op(32'hFFFF_FFFF, 32'd32, "oor32");
        do_op(32'hFFFF_FFFF, 32'h8000_0000, "oor_msb");
        do_op(32'hFFFF_FFFF, 32'd37, "oor37");

        // Start pulsed mid-shift must be ignored
        @(negedge clk);
        a = 32'h1234_5678; b = 32'd8; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 32'd0; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone       = 0;
        res_at_done = 32'hXXXX_XXXX;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                res_at_done = Res;
            end
        end
        chk("ign.count", ndone, 32'd1);
        chk("ign.res", res_at_done, 32'h3456_7800);

        // Back-to-back: start held, new request accepted in the DONE cycle
        @(negedge clk);
        a = 32'h0000_0003; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b.done1", {31'd0, done}, 32'd1);
        chk("b2b.res1", Res, 32'h0000_0006);
        b = 32'd2;
        @(posedge clk);
        #1;
        chk("b2b.nobubble", {31'd0, busy}, 32'd1);
        chk("b2b.done_low", {31'd0, done}, 32'd0);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b.still_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b.done2", {31'd0, done}, 32'd1);
        chk("b2b.res2", Res, 32'h0000_000C);
        @(posedge clk);
        #1;
        chk("b2b.idle", {31'd0, done | busy}, 32'd0);

        // Reset dropped at stage 2 aborts the operation
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid.busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid.res", Res, 32'd0);
        chk("mid.busy", {31'd0, busy}, 32'd0);
        chk("mid.done", {31'd0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mid.nodone", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_op(32'hFFFF_FFFF, 32'd3, "restart");

        // Random operands with a mix of in-range and out-of-range amounts
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(32, 63);
                default: rb = $urandom_range(0, 31);
            endcase
            do_op($urandom, rb, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
